accumulator_multichannel: RTL and testbench

Multi-channel, parametrised accumulator with a registered input stage, per-channel accumulator banks, a signed/unsigned mode, a load path and a registered readback port. It serves several independent sample streams that share one adder and are interleaved on one input bus. It is the arithmetic-library successor to the single-channel N-bit accumulator. Sticky per-channel overflow lets software detect wrap without polling every cycle.

---
 rtl/accumulator_multichannel.sv | 138 +++++++++++++
 tb/tb_accumulator_multichannel.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/accumulator_multichannel.sv
// Multi-channel accumulator: registered input stage feeding a shared adder that updates one
// of CH = 2**CHW accumulator banks per cycle, with per-channel carry, sticky overflow, a load
// path and an independent registered readback port.
// Optional feature: define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module accumulator_multichannel #(
    parameter int unsigned N   = 8,
    parameter int unsigned CHW = 2
) (
    input  logic           clk,
    input  logic           aclr,
    input  logic           in_valid_i,
    input  logic [CHW-1:0] in_ch_i,
    input  logic           in_load_i,
    input  logic           signed_mode_i,
    input  logic [N-1:0]   a_i,
    input  logic           rd_en_i,
    input  logic [CHW-1:0] rd_ch_i,
    output logic           rd_valid_o,
    output logic [N-1:0]   rd_data_o,
    output logic           rd_carry_o,
    output logic           rd_overflow_o
);

    localparam int unsigned CH = 2 ** CHW;

    // Stage-1 input register
    logic           s1_valid_q;
    logic [CHW-1:0] s1_ch_q;
    logic           s1_load_q;
    logic           s1_signed_q;
    logic [N-1:0]   s1_a_q;

    // Per-channel state
    logic [N-1:0]   acc_q   [CH];
    logic [CH-1:0]  carry_q;
    logic [CH-1:0]  ovf_q;

    // Adder datapath for the channel addressed by stage 1
    logic [N-1:0]   acc_cur;
    logic [N:0]     sum;
    logic           ovf_evt;
    logic [N-1:0]   acc_d;

    // Readback registers
    logic           rd_valid_q;
    logic [N-1:0]   rd_data_q;
    logic           rd_carry_q;
    logic           rd_overflow_q;

    // Capture the incoming sample; A is only loaded alongside a valid sample.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_load_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_a_q      <= '0;
        end else begin
            s1_valid_q  <= in_valid_i;
            s1_ch_q     <= in_ch_i;
            s1_load_q   <= in_load_i;
            s1_signed_q <= signed_mode_i;
            if (in_valid_i) begin
                s1_a_q <= a_i;
            end
        end
    end

    // Compute the sum, overflow event and (optionally clamped) result for the target channel.
    always_comb begin
        acc_cur = acc_q[s1_ch_q];
        sum     = {1'b0, acc_cur} + {1'b0, s1_a_q};
        if (s1_signed_q) begin
            ovf_evt = (s1_a_q[N-1] == acc_cur[N-1]) && (sum[N-1] != s1_a_q[N-1]);
        end else begin
            ovf_evt = sum[N];
        end
        acc_d = sum[N-1:0];
`ifdef ACC_SATURATE_EN
        if (ovf_evt) begin
            if (!s1_signed_q) begin
                acc_d = {N{1'b1}};
            end else if (s1_a_q[N-1]) begin
                // Both operands negative: clamp to the most negative value
                acc_d = {1'b1, {(N-1){1'b0}}};
            end else begin
                acc_d = {1'b0, {(N-1){1'b1}}};
            end
        end
`endif
    end

    // Update only the addressed bank; all other channels hold.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < int'(CH); i++) begin
                acc_q[i] <= '0;
            end
            carry_q <= '0;
            ovf_q   <= '0;
        end else if (s1_valid_q) begin
            if (s1_load_q) begin
                acc_q[s1_ch_q]   <= s1_a_q;
                carry_q[s1_ch_q] <= 1'b0;
                ovf_q[s1_ch_q]   <= 1'b0;
            end else begin
                acc_q[s1_ch_q]   <= acc_d;
                carry_q[s1_ch_q] <= sum[N];
                if (ovf_evt) begin
                    ovf_q[s1_ch_q] <= 1'b1;
                end
            end
        end
    end

    // Readback samples pre-update state, so a same-cycle write is not visible yet.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_carry_q    <= 1'b0;
            rd_overflow_q <= 1'b0;
        end else if (rd_en_i) begin
            rd_valid_q    <= 1'b1;
            rd_data_q     <= acc_q[rd_ch_i];
            rd_carry_q    <= carry_q[rd_ch_i];
            rd_overflow_q <= ovf_q[rd_ch_i];
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign rd_carry_o    = rd_carry_q;
    assign rd_overflow_o = rd_overflow_q;

endmodule

// File: tb/tb_accumulator_multichannel.sv
// Directed bench for accumulator_multichannel (N=8, CHW=2); expectations follow
// ACC_SATURATE_EN when it is defined.
module tb_accumulator_multichannel;

    localparam int unsigned N   = 8;
    localparam int unsigned CHW = 2;

`ifdef ACC_SATURATE_EN
    localparam logic [7:0] UWrapVal  = 8'd255;
    localparam logic [7:0] SOvfVal   = 8'h7F;
    localparam logic [7:0] SNextVal  = 8'h75;
`else
    localparam logic [7:0] UWrapVal  = 8'd44;
    localparam logic [7:0] SOvfVal   = 8'h96;
    localparam logic [7:0] SNextVal  = 8'h8C;
`endif

    logic           clk = 1'b0;
    logic           aclr;
    logic           in_valid;
    logic [CHW-1:0] in_ch;
    logic           in_load;
    logic           signed_mode;
    logic [N-1:0]   a;
    logic           rd_en;
    logic [CHW-1:0] rd_ch;
    logic           rd_valid;
    logic [N-1:0]   rd_data;
    logic           rd_carry;
    logic           rd_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    accumulator_multichannel #(
        .N   (N),
        .CHW (CHW)
    ) dut (
        .clk           (clk),
        .aclr          (aclr),
        .in_valid_i    (in_valid),
        .in_ch_i       (in_ch),
        .in_load_i     (in_load),
        .signed_mode_i (signed_mode),
        .a_i           (a),
        .rd_en_i       (rd_en),
        .rd_ch_i       (rd_ch),
        .rd_valid_o    (rd_valid),
        .rd_data_o     (rd_data),
        .rd_carry_o    (rd_carry),
        .rd_overflow_o (rd_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CHW-1:0] ch, input logic ld, input logic sg,
                        input logic [N-1:0] val);
        in_valid    = 1'b1;
        in_ch       = ch;
        in_load     = ld;
        signed_mode = sg;
        a           = val;
        tick();
        in_valid = 1'b0;
        in_load  = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [CHW-1:0] ch, input logic [N-1:0] d,
                            input logic c, input logic o);
        rd_en = 1'b1;
        rd_ch = ch;
        tick();
        rd_en = 1'b0;
        chk({tag, ".valid"}, {31'd0, rd_valid}, 32'd1);
        chk({tag, ".data"}, {24'd0, rd_data}, {24'd0, d});
        chk({tag, ".carry"}, {31'd0, rd_carry}, {31'd0, c});
        chk({tag, ".ovf"}, {31'd0, rd_overflow}, {31'd0, o});
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        tick();
    endtask

    initial begin
        aclr        = 1'b1;
        in_valid    = 1'b0;
        in_ch       = '0;
        in_load     = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        rd_en       = 1'b1;
        rd_ch       = '0;

        // Reset held with a read request: output stays invalid and zero
        tick();
        tick();
        chk("rst_hold.valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_hold.data", {24'd0, rd_data}, 32'd0);
        rd_en = 1'b0;
        aclr  = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            read_chk($sformatf("rst_ch%0d", i), CHW'(i), 8'd0, 1'b0, 1'b0);
        end

        // Unsigned wrap on ch1: 200 + 100
        send(2'd1, 1'b0, 1'b0, 8'd200);
        send(2'd1, 1'b0, 1'b0, 8'd100);
        tick();
        read_chk("uwrap", 2'd1, UWrapVal, 1'b1, 1'b1);
        // No read request: valid drops, data holds
        tick();
        chk("rd_idle.valid", {31'd0, rd_valid}, 32'd0);
        chk("rd_idle.hold", {24'd0, rd_data}, {24'd0, UWrapVal});

        // Signed overflow on ch2: 100 + 50, then -10 keeps sticky ovf
        send(2'd2, 1'b0, 1'b1, 8'd100);
        send(2'd2, 1'b0, 1'b1, 8'd50);
        tick();
        read_chk("sovf", 2'd2, SOvfVal, 1'b0, 1'b1);
        send(2'd2, 1'b0, 1'b1, 8'hF6);
        tick();
        read_chk("sovf_sticky", 2'd2, SNextVal, 1'b1, 1'b1);

        // Interleave on fresh state, one sample per cycle
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) send(2'd0, 1'b0, 1'b0, 8'd1);
            else            send(2'd3, 1'b0, 1'b0, 8'd2);
        end
        tick();
        read_chk("ilv_ch0", 2'd0, 8'd5, 1'b0, 1'b0);
        read_chk("ilv_ch1", 2'd1, 8'd0, 1'b0, 1'b0);
        read_chk("ilv_ch2", 2'd2, 8'd0, 1'b0, 1'b0);
        read_chk("ilv_ch3", 2'd3, 8'd8, 1'b0, 1'b0);

        // Load path: overflow ch1, load 7, add 3 back-to-back, read during the load write
        send(2'd1, 1'b0, 1'b0, 8'd200);
        send(2'd1, 1'b0, 1'b0, 8'd100);
        send(2'd1, 1'b1, 1'b0, 8'd7);
        in_valid = 1'b1;
        in_ch    = 2'd1;
        in_load  = 1'b0;
        a        = 8'd3;
        rd_en    = 1'b1;
        rd_ch    = 2'd1;
        tick();
        in_valid = 1'b0;
        rd_en    = 1'b0;
        chk("ld_pre.valid", {31'd0, rd_valid}, 32'd1);
        chk("ld_pre.data", {24'd0, rd_data}, {24'd0, UWrapVal});
        chk("ld_pre.carry", {31'd0, rd_carry}, 32'd1);
        chk("ld_pre.ovf", {31'd0, rd_overflow}, 32'd1);
        tick();
        read_chk("ld_post", 2'd1, 8'd10, 1'b0, 1'b0);

        // Reset mid-stream: sample sitting in stage 1 is discarded
        send(2'd2, 1'b0, 1'b0, 8'd55);
        aclr = 1'b1;
        #2;
        aclr = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            read_chk($sformatf("midrst_ch%0d", i), CHW'(i), 8'd0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
